// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard / sequencing controller with optional performance counters
//
// Ports:
//   clk, rst (async, active-low)
//   d_icode_i, d_srcA_i, d_srcB_i      decode-stage icode and source register IDs
//   e_icode_i, e_dstM_i, e_cnd_i       execute-stage icode, memory destination, branch condition
//   f_stall_o, d_stall_o               fetch / decode pipeline-register stall
//   d_bubble_o, e_bubble_o             decode / execute pipeline-register bubble
//   halted_o                           core has stopped (left only by reset)
//   state_o                            RUN=0, RET=1, DRAIN=2, HALTED=3
//   stall_cnt_o, bubble_cnt_o          saturating performance counters
//
// Build option: PIPE_CTRL_PERF_EN enables the performance counters; when it is
// undefined the counter ports read as zero and no counter flops exist.

module pipe_ctrl #(
    parameter int         CNT_W = 16,
    parameter logic [7:0] RNONE = 8'h0F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d_icode_i,
    input  logic [7:0]       d_srcA_i,
    input  logic [7:0]       d_srcB_i,
    input  logic [7:0]       e_icode_i,
    input  logic [7:0]       e_dstM_i,
    input  logic             e_cnd_i,
    output logic             f_stall_o,
    output logic             d_stall_o,
    output logic             d_bubble_o,
    output logic             e_bubble_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [7:0] I_HALT   = 8'h00;
    localparam logic [7:0] I_MRMOVL = 8'h05;
    localparam logic [7:0] I_JXX    = 8'h07;
    localparam logic [7:0] I_RET    = 8'h09;
    localparam logic [7:0] I_POPL   = 8'h0B;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_RET    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       lu;
    logic       mp;

    // Load-use: a load in execute whose destination feeds the instruction in decode.
    assign lu = ((e_icode_i == I_MRMOVL) || (e_icode_i == I_POPL)) &&
                (e_dstM_i != RNONE) &&
                ((e_dstM_i == d_srcA_i) || (e_dstM_i == d_srcB_i));

    // Mispredict: jumps are predicted taken, so a not-taken jump in execute squashes.
    assign mp = (e_icode_i == I_JXX) && !e_cnd_i;

    assign state_o = state;

    // Controls are combinational so hazards act in the cycle they are seen.
    // Gating with rst keeps every output low while reset is held.
    always_comb begin
        f_stall_o  = 1'b0;
        d_stall_o  = 1'b0;
        d_bubble_o = 1'b0;
        e_bubble_o = 1'b0;
        halted_o   = 1'b0;
        if (rst) begin
            case (state)
                S_RUN: begin
                    if (lu) begin
                        f_stall_o  = 1'b1;
                        d_stall_o  = 1'b1;
                        e_bubble_o = 1'b1;
                    end else if (mp) begin
                        d_bubble_o = 1'b1;
                        e_bubble_o = 1'b1;
                    end else if (d_icode_i == I_RET) begin
                        f_stall_o  = 1'b1;
                        d_bubble_o = 1'b1;
                    end else if (d_icode_i == I_HALT) begin
                        f_stall_o  = 1'b1;
                    end
                end
                S_RET: begin
                    // Decode is already bubbling, so a load-use stall is not needed here
                    // (and would clash with the bubble); a mispredict still squashes execute.
                    f_stall_o  = 1'b1;
                    d_bubble_o = 1'b1;
                    e_bubble_o = mp;
                end
                S_DRAIN: begin
                    f_stall_o  = 1'b1;
                    d_bubble_o = 1'b1;
                end
                S_HALTED: begin
                    f_stall_o  = 1'b1;
                    d_stall_o  = 1'b1;
                    halted_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer. RET: counter 1 -> 0 -> back to RUN gives three stalled fetch
    // cycles counting the acceptance cycle. DRAIN: counter 2 -> 1 -> HALTED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            cnt   <= 2'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (!lu && !mp) begin
                        if (d_icode_i == I_RET) begin
                            cnt   <= 2'd1;
                            state <= S_RET;
                        end else if (d_icode_i == I_HALT) begin
                            cnt   <= 2'd2;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_RET: begin
                    if (cnt == 2'd0) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt <= 2'd1) begin
                        cnt   <= 2'd0;
                        state <= S_HALTED;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_HALTED: ;
                default: begin
                    state <= S_RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Saturating counters, frozen once the core has halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (state != S_HALTED) begin
            if (f_stall_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((d_bubble_o || e_bubble_o) && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt;
    assign bubble_cnt_o = bubble_cnt;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected control vector: {f_stall, d_stall, d_bubble, e_bubble, halted, state[1:0]}
    localparam logic [6:0] E_NONE   = 7'b0000000;
    localparam logic [6:0] E_LU     = 7'b1101000;
    localparam logic [6:0] E_MP     = 7'b0011000;
    localparam logic [6:0] E_RET_T  = 7'b1010000;
    localparam logic [6:0] E_RET_S  = 7'b1010001;
    localparam logic [6:0] E_RET_MP = 7'b1011001;
    localparam logic [6:0] E_HALT_T = 7'b1000000;
    localparam logic [6:0] E_DRAIN  = 7'b1010010;
    localparam logic [6:0] E_HALTED = 7'b1100111;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       d_icode, d_srcA, d_srcB, e_icode, e_dstM;
    logic             e_cnd;
    logic             f_stall, d_stall, d_bubble, e_bubble, halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    typedef struct {
        string            tag;
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] bc;
    } exp_t;

    exp_t             sbq[$];
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_bub   = '0;
    int               n_checks = 0;
    int               n_fail   = 0;

    pipe_ctrl #(.CNT_W(CNT_W), .RNONE(8'h0F)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_icode_i    (d_icode),
        .d_srcA_i     (d_srcA),
        .d_srcB_i     (d_srcB),
        .e_icode_i    (e_icode),
        .e_dstM_i     (e_dstM),
        .e_cnd_i      (e_cnd),
        .f_stall_o    (f_stall),
        .d_stall_o    (d_stall),
        .d_bubble_o   (d_bubble),
        .e_bubble_o   (e_bubble),
        .halted_o     (halted),
        .state_o      (state),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the expected outputs for the cycle just driven; counters show the
    // cycles before this one, then the model accounts for this cycle.
    task automatic push_exp(input string tag, input logic [6:0] ctrl);
        exp_t e;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.sc   = m_stall;
        e.bc   = m_bub;
        sbq.push_back(e);
        if (PERF && (ctrl[1:0] != 2'd3)) begin
            if (ctrl[6] && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if ((ctrl[4] || ctrl[3]) && (m_bub != '1)) m_bub = m_bub + 1'b1;
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        check_eq(e.tag, {25'd0, f_stall, d_stall, d_bubble, e_bubble, halted, state}, {25'd0, e.ctrl});
        check_eq({e.tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e.sc});
        check_eq({e.tag, "_bubble_cnt"}, {28'd0, bubble_cnt}, {28'd0, e.bc});
        check_eq({e.tag, "_stall_and_bubble"}, {31'd0, d_stall & d_bubble}, 32'd0);
    endtask

    task automatic set_in(input logic [7:0] di, input logic [7:0] sa, input logic [7:0] sb,
                          input logic [7:0] ei, input logic [7:0] edm, input logic ec);
        d_icode = di;
        d_srcA  = sa;
        d_srcB  = sb;
        e_icode = ei;
        e_dstM  = edm;
        e_cnd   = ec;
    endtask

    // One clock cycle: apply inputs just after the edge, check at the falling edge.
    task automatic drive(input string tag, input logic [7:0] di, input logic [7:0] sa,
                         input logic [7:0] sb, input logic [7:0] ei, input logic [7:0] edm,
                         input logic ec, input logic [6:0] exp);
        @(posedge clk);
        #1;
        set_in(di, sa, sb, ei, edm, ec);
        push_exp(tag, exp);
        @(negedge clk);
        pop_check();
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        drive(tag, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, exp);
    endtask

    // Assert reset mid-cycle, check it acts at once, release between edges
    // holding decode icode hold_di, and check the live outputs after release.
    task automatic do_reset(input string tag, input logic [7:0] hold_di, input logic [6:0] post);
        rst = 1'b0;
        set_in(hold_di, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0);
        #1;
        m_stall = '0;
        m_bub   = '0;
        push_exp({tag, "_in_reset"}, E_NONE);
        pop_check();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        push_exp({tag, "_released"}, post);
        pop_check();
    endtask

    initial begin
        // Reset held with a load-use pattern on the inputs: outputs must stay low.
        rst = 1'b0;
        set_in(8'h09, 8'h0F, 8'h03, 8'h05, 8'h03, 1'b0);
        #3;
        push_exp("reset_state", E_NONE);
        pop_check();
        @(negedge clk);
        set_in(8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0);
        rst = 1'b1;

        // Load-use and its negative cases
        drive("lu_mrmovl_srcB", 8'h01, 8'h0F, 8'h03, 8'h05, 8'h03, 1'b0, E_LU);
        drive("lu_rnone",       8'h01, 8'h0F, 8'h0F, 8'h05, 8'h0F, 1'b0, E_NONE);
        drive("lu_popl_srcA",   8'h01, 8'h02, 8'h0F, 8'h0B, 8'h02, 1'b0, E_LU);
        drive("lu_no_match",    8'h01, 8'h04, 8'h06, 8'h05, 8'h02, 1'b0, E_NONE);
        drive("lu_not_load",    8'h01, 8'h02, 8'h0F, 8'h06, 8'h02, 1'b0, E_NONE);

        // Mispredict
        drive("mp_not_taken",   8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, E_MP);
        drive("mp_taken",       8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b1, E_NONE);

        // Ret: three stalled fetch cycles
        drive("ret_t0", 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, E_RET_T);
        idle("ret_t1", E_RET_S);
        idle("ret_t2", E_RET_S);
        idle("ret_t3", E_NONE);

        // Priority: ret blocked by load-use, accepted next cycle
        drive("prio_ret_lu", 8'h09, 8'h04, 8'h0F, 8'h05, 8'h04, 1'b0, E_LU);
        drive("prio_ret_t0", 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, E_RET_T);
        idle("prio_ret_t1", E_RET_S);
        idle("prio_ret_t2", E_RET_S);
        idle("prio_ret_t3", E_NONE);

        // Halt blocked by mispredict, then mispredict during ret
        drive("prio_halt_mp", 8'h00, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, E_MP);
        idle("prio_halt_none", E_NONE);
        drive("retmp_t0", 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, E_RET_T);
        drive("retmp_t1", 8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, E_RET_MP);
        drive("retmp_t2", 8'h01, 8'h03, 8'h0F, 8'h05, 8'h03, 1'b0, E_RET_S);
        idle("retmp_t3", E_NONE);

        // Reset in the middle of ret leaves no residual stall
        drive("ret_mid_t0", 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, E_RET_T);
        idle("ret_mid_t1", E_RET_S);
        do_reset("ret_abort", 8'h01, E_NONE);
        idle("ret_abort_after", E_NONE);

        // Twenty stall cycles saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            drive("sat_lu", 8'h01, 8'h0F, 8'h05, 8'h05, 8'h05, 1'b0, E_LU);
        end
        idle("sat_after", E_NONE);
        check_eq("stall_sat", {28'd0, stall_cnt}, PERF ? 32'd15 : 32'd0);

        // Halt: drain two cycles (ignoring hazards), then hold
        drive("halt_t0", 8'h00, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, E_HALT_T);
        drive("drain_t1_lu", 8'h01, 8'h03, 8'h0F, 8'h05, 8'h03, 1'b0, E_DRAIN);
        drive("drain_t2_mp", 8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, E_DRAIN);
        idle("halted_t3", E_HALTED);
        for (int i = 0; i < 20; i++) begin
            drive("halted_hold", 8'h09, 8'h0F, 8'h03, (i % 2 == 0) ? 8'h05 : 8'h07,
                  8'h03, 1'b0, E_HALTED);
        end

        // Leave HALTED by reset; ret held in decode is taken on the first edge
        do_reset("halt_exit", 8'h09, E_RET_T);
        idle("post_reset_t1", E_RET_S);
        idle("post_reset_t2", E_RET_S);
        idle("post_reset_t3", E_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 16: width of each performance counter.
REQ-002 SHALL provide parameter RNONE, default 8'h0F: register ID meaning "no register".
REQ-003 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL provide port d_icode_i, input, 8: icode of the instruction in decode.
REQ-006 SHALL provide ports d_srcA_i and d_srcB_i, input, 8 each: decode source register IDs.
REQ-007 SHALL provide port e_icode_i, input, 8: icode of the instruction in execute.
REQ-008 SHALL provide port e_dstM_i, input, 8: execute-stage memory destination register.
REQ-009 SHALL provide port e_cnd_i, input, 1: execute branch condition, 1 = taken.
REQ-010 SHALL provide ports f_stall_o, d_stall_o, d_bubble_o and e_bubble_o, output, 1 each: pipeline-register controls.
REQ-011 SHALL provide port halted_o, output, 1: the core has stopped.
REQ-012 SHALL provide port state_o, output, 2: FSM state, encoded RUN=0, RET=1, DRAIN=2, HALTED=3.
REQ-013 SHALL provide ports stall_cnt_o and bubble_cnt_o, output, CNT_W each: performance counters.

Function
REQ-014 SHALL decode the icodes HALT=0, MRMOVL=5, JXX=7, RET=9 and POPL=B.
REQ-015 SHALL detect load-use (LU) when e_icode_i is MRMOVL or POPL, e_dstM_i != RNONE, and e_dstM_i equals d_srcA_i or d_srcB_i.
REQ-016 SHALL detect mispredict (MP) when e_icode_i == JXX and e_cnd_i == 0.
REQ-017 SHALL compute all control outputs combinationally from the inputs and the current state, in the same cycle (zero latency).
REQ-018 SHALL, on LU in RUN state, assert f_stall_o, d_stall_o and e_bubble_o.
REQ-019 SHALL, on MP in RUN or RET state, assert d_bubble_o and e_bubble_o, and SHALL NOT assert f_stall_o for MP alone.
REQ-020 SHALL, in RUN with no LU and no MP, when d_icode_i == RET, assert f_stall_o and d_bubble_o, load the counter with 1, and go to RET.
REQ-021 SHALL, in RET, assert f_stall_o and d_bubble_o; if the counter is 0, go to RUN next cycle, else decrement it. This gives exactly 3 cycles of fetch stall per ret.
REQ-022 SHALL, in RUN with no LU and no MP, when d_icode_i == HALT, assert f_stall_o, load the counter with 2, and go to DRAIN.
REQ-023 SHALL, in DRAIN, assert f_stall_o and d_bubble_o, decrement the counter, and go to HALTED when it reaches 0.
REQ-024 SHALL, in HALTED, hold f_stall_o=1, d_stall_o=1 and halted_o=1, with d_bubble_o=0 and e_bubble_o=0; HALTED is left only by reset.
REQ-025 SHALL resolve priority as LU > MP > RET/HALT:
- RET or HALT in decode during LU or MP is not accepted that cycle.
- If LU and MP are both true, LU wins.
REQ-026 SHALL ignore LU and MP in DRAIN and HALTED.
REQ-027 SHALL never assert d_stall_o and d_bubble_o in the same cycle.

Reset
REQ-028 SHALL, while rst is 0, force state=RUN, counter=0, performance counters=0 and every output to 0, independent of clk.
REQ-029 SHALL, on reset assertion in the middle of RET or DRAIN, abandon the sequence with no residual stall after release.
REQ-030 SHALL evaluate inputs normally on the first rising edge after release.

Configuration
REQ-031 SHALL, with PIPE_CTRL_PERF_EN defined:
- increment stall_cnt_o each cycle f_stall_o=1;
- increment bubble_cnt_o each cycle d_bubble_o or e_bubble_o is 1;
- saturate both counters at 2^CNT_W-1;
- freeze both counters in HALTED.
REQ-032 SHALL, without PIPE_CTRL_PERF_EN, keep the ports present, tie them to 0, and instantiate no counter flops.

Verification
REQ-033 SHALL cover load-use: e_icode=5, e_dstM=3, d_srcB=3 -> f_stall=d_stall=e_bubble=1 that cycle; with d_srcA=d_srcB=F, e_dstM=F -> all 0.
REQ-034 SHALL cover mispredict: e_icode=7, e_cnd=0 -> d_bubble=e_bubble=1, f_stall=0; with e_cnd=1 -> all 0.
REQ-035 SHALL cover ret: d_icode=9 for one cycle at T -> f_stall=d_bubble=1 at T, T+1, T+2; 0 at T+3; state_o=1 at T+1, T+2; state_o=0 at T+3.
REQ-036 SHALL cover halt: d_icode=0 at T -> state_o=2 at T+1; state_o=3 and halted_o=1 from T+3 and held for 20 further cycles; rst low -> state_o=0 immediately.
REQ-037 SHALL cover priority: d_icode=9 with LU true -> no RET entry; next cycle with LU false -> RET entered.
REQ-038 SHALL cover counters (PIPE_CTRL_PERF_EN, CNT_W=4): 20 stall cycles -> stall_cnt_o=15; without the macro -> stall_cnt_o=0.
